// File: rtl/core_sysid_pkg.sv
// Shared types and constants for the CORE system-ID checker: FSM states,
// slave word addresses and datapath widths.
package core_sysid_pkg;

    localparam int DATA_W = 32;
    localparam int WAIT_W = 3;
    localparam int ATT_W  = 4;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_CHECK,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/core_sysid_wait_timer.sv
// Loadable down-counter pacing each system-ID read; expired_o is high while
// the count sits at zero, so a load of N gives N+1 cycles until capture.
module core_sysid_wait_timer
    import core_sysid_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_value_i,
    output logic              expired_o
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - WAIT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/core_sysid_checker.sv
// Reads both system-ID words, compares them with build-time values and
// retries whole passes on mismatch; verdict and captured words are registered.
module core_sysid_checker
    import core_sysid_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID  = 32'd0,
    parameter logic [DATA_W-1:0] EXPECTED_TS  = 32'd1450868559,
    parameter int unsigned       READ_LATENCY = 1,
    parameter int unsigned       RETRY_LIMIT  = 3,
    parameter bit                AUTO_START   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              address,
    input  logic [DATA_W-1:0] readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] id_value,
    output logic [DATA_W-1:0] ts_value,
    output logic [ATT_W-1:0]  attempts
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_LATENCY);
    localparam logic [ATT_W-1:0]  RETRY_MAX = ATT_W'(RETRY_LIMIT);

    state_e             state_q, state_d;
    logic               auto_q, auto_d;
    logic               busy_q, done_q;
    logic               pass_q, pass_d;
    logic [DATA_W-1:0]  id_q, id_d;
    logic [DATA_W-1:0]  ts_q, ts_d;
    logic [ATT_W-1:0]   att_q, att_d;
    logic               timer_load;
    logic               timer_expired;

    core_sysid_wait_timer u_wait_timer (
        .clock        (clock),
        .reset        (reset),
        .load_i       (timer_load),
        .load_value_i (WAIT_LOAD),
        .expired_o    (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        auto_d     = auto_q;
        pass_d     = pass_q;
        id_d       = id_q;
        ts_d       = ts_q;
        att_d      = att_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start || auto_q) begin
                    state_d    = ST_RD_ID;
                    auto_d     = 1'b0;
                    att_d      = ATT_W'(1);
                    pass_d     = 1'b0;
                    timer_load = 1'b1;
                end
            end
            ST_RD_ID: begin
                if (timer_expired) begin
                    id_d       = readdata;
                    state_d    = ST_RD_TS;
                    timer_load = 1'b1;
                end
            end
            ST_RD_TS: begin
                if (timer_expired) begin
                    ts_d    = readdata;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (id_q == EXPECTED_ID && ts_q == EXPECTED_TS) begin
                    pass_d  = 1'b1;
                    state_d = ST_FINISH;
                // A saturated counter also ends the check, so it can never spin forever.
                end else if (att_q <= RETRY_MAX && att_q != '1) begin
                    att_d      = att_q + ATT_W'(1);
                    state_d    = ST_RD_ID;
                    timer_load = 1'b1;
                end else begin
                    pass_d  = 1'b0;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            auto_q  <= AUTO_START;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
            att_q   <= '0;
        end else begin
            state_q <= state_d;
            auto_q  <= auto_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_FINISH);
            pass_q  <= pass_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            att_q   <= att_d;
        end
    end

    assign address  = (state_q == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign id_value = id_q;
    assign ts_value = ts_q;
    assign attempts = att_q;

endmodule

// File: doc/core_sysid_checker.md
# core_sysid_checker

Sequencer that reads the two words of the CORE system-ID slave and checks them against build-time expected values. It drives the slave's `address` input, waits a configurable read latency, captures `readdata`, compares it, and retries on mismatch. It sits beside the system-ID slave and provides boot firmware and board logic with a registered pass/fail verdict and the captured values.

## Interface
Parameters:
- `EXPECTED_ID`, default 0: expected word at address 0.
- `EXPECTED_TS`, default 1450868559: expected word at address 1 (build timestamp).
- `READ_LATENCY`, default 1: wait cycles before capture (0..7). 0 captures in the same cycle the address is driven.
- `RETRY_LIMIT`, default 3: extra full passes after the first failed pass (0..15).
- `AUTO_START`, default 1: when 1, a check starts automatically in the first cycle after reset.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a check; sampled only in IDLE
- `address`  out  1  drives the system-ID slave address
- `readdata`  in  32  system-ID slave read data
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at the end of a check
- `pass`  out  1  sticky result of the last completed check
- `id_value`  out  32  last captured address-0 word
- `ts_value`  out  32  last captured address-1 word
- `attempts`  out  4  passes used in the last check (1..RETRY_LIMIT+1)

## Operation
- States: IDLE, RD_ID, RD_TS, CHECK, FINISH.
- IDLE: `address`=0. Exits to RD_ID when `start`=1, or on the first cycle after reset when AUTO_START=1. On entry to RD_ID, clear the attempt counter to 1 and clear `pass`.
- RD_ID: `address`=0. The wait counter counts 0..READ_LATENCY. On the cycle the count equals READ_LATENCY, latch `readdata` into `id_value`, clear the counter and go to RD_TS.
- RD_TS: `address`=1. Same counting. On the last cycle, latch `readdata` into `ts_value` and go to CHECK.
- CHECK: compare `id_value` with EXPECTED_ID and `ts_value` with EXPECTED_TS.
  - Both equal: set `pass`=1 and go to FINISH.
  - Otherwise, if attempts ≤ RETRY_LIMIT: increment attempts and go to RD_ID.
  - Otherwise: set `pass`=0 and go to FINISH.
- FINISH: `done`=1 for this one cycle, then go to IDLE.
- `start` outside IDLE is ignored, not queued. `start` high in the FINISH cycle is also ignored. `start` held high in IDLE starts back-to-back checks.
- The attempt counter saturates at 15, and the RETRY_LIMIT range guarantees it never wraps.
- Compares are full 32-bit equality. No masking.
- Reset at any point, including mid-read: state becomes IDLE within the same edge and every output takes its reset value. No partial `done` is issued.

## Timing
- Reset values: `address`=0, `busy`=0, `done`=0, `pass`=0, `id_value`=0, `ts_value`=0, `attempts`=0, state IDLE.
- All outputs are registered except `address`, which is decoded from the state register (glitch-free, no input path).
- Let L = READ_LATENCY. Per pass: RD_ID takes L+1 cycles, RD_TS takes L+1 cycles, CHECK takes 1 cycle.
- Latency from the edge that samples `start` to the `done` pulse: passes·(2L+3)+1 cycles. The first pass with L=1 gives 6 cycles.
- `busy` rises the cycle after `start` is sampled and falls the cycle after `done`.
- `pass`, `id_value`, `ts_value` and `attempts` are stable from `done` until the next check enters RD_ID.

## Structure
- Package `core_sysid_pkg`:
  - state enum
  - address constants `SYSID_ADDR_ID`=0 and `SYSID_ADDR_TS`=1
  - widths: data 32, wait counter 3, attempt counter 4
- Sub-module `core_sysid_wait_timer`: loadable 3-bit down-counter with a `expired` output, reused by RD_ID and RD_TS.
- The FSM, capture registers and compare stay in the top level.

## Test plan
- Nominal: AUTO_START=1, slave model returns 0 and 1450868559, L=1 → `done` 6 cycles after reset release; `pass`=1, `attempts`=1; `address` sequence 0,0,1,1.
- Transient mismatch: timestamp returns 0 on the first pass and is correct afterwards, RETRY_LIMIT=3 → `pass`=1, `attempts`=2, `done` at 11 cycles.
- Persistent mismatch: ID returns 0xDEADBEEF, RETRY_LIMIT=3 → `pass`=0, `attempts`=4, `id_value`=0xDEADBEEF, exactly one `done` pulse.
- Latency sweep: L=0 and L=7 → capture aligns with the last wait cycle; `done` at 4 and 18 cycles respectively.
- Reset mid-RD_TS → next cycle IDLE, all outputs 0, no `done`. With AUTO_START=0, stays IDLE until `start` is asserted.
- `start` pulsed while busy and in the FINISH cycle → ignored, exactly one check runs. `start` held high → consecutive checks separated by one IDLE cycle.
